kbd_event_fifo: RTL and testbench

Parametrised keyboard event queue in the CLK50 domain between the PS/2 byte receiver and the CPU-visible keyboard registers. It decodes raw scancode bytes (0xE0 extended prefix, 0xF0 break prefix) into 10-bit key events and optionally reports key releases. It can filter typematic repeats and buffers events in a DEPTH-entry FIFO that uses every slot. It also exposes count and a sticky overflow flag.

---
 rtl/kbd_pkg.sv | 26 ++
 rtl/kbd_event_fifo_if.sv | 27 ++
 rtl/kbd_fifo.sv | 57 +++++
 rtl/kbd_event_fifo.sv | 116 +++++++++++
 tb/tb_kbd_event_fifo.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// Shared scancode constants, event layout and decoder state type for the
// keyboard event queue.
package kbd_pkg;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_ERR0 = 8'h00;
    localparam logic [7:0] SC_ERR1 = 8'hFF;

    localparam int EV_BRK = 9;
    localparam int EV_EXT = 8;
    localparam int EV_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_t;

    // True for bytes that complete a key event (not a prefix, not an error code).
    function automatic logic is_code_byte(input logic [7:0] b);
        return !(b inside {SC_EXT, SC_BRK, SC_ERR0, SC_ERR1});
    endfunction

endpackage

// File: rtl/kbd_event_fifo_if.sv
// CPU-side view of the keyboard event queue: pop/clear strobes in,
// head event, occupancy and overflow status out.
interface kbd_event_fifo_if #(
    parameter int DEPTH = 32
);
    import kbd_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic            pop;
    logic            clear;
    logic [EV_W-1:0] ev_data;
    logic            ev_valid;
    logic [AW:0]     count;
    logic            overflow;

    modport master (
        output pop, clear,
        input  ev_data, ev_valid, count, overflow
    );

    modport slave (
        input  pop, clear,
        output ev_data, ev_valid, count, overflow
    );

endinterface

// File: rtl/kbd_fifo.sv
// Generic single-clock FIFO using all DEPTH slots; clear has priority over
// push and pop, and a push into a full FIFO is accepted only alongside a pop.
module kbd_fifo #(
    parameter int  DEPTH = 32,
    parameter int  WIDTH = 10,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK50,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count gates every read, so
    // stale contents are never observed and the array can map to plain RAM.
    always_ff @(posedge CLK50) begin
        if (do_push && !clear)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge CLK50) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/kbd_event_fifo.sv
// PS/2 scancode decoder feeding a key-event FIFO: byte handshake, prefix
// FSM, held-key repeat filter and sticky overflow flag.
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       CLK50,
    input  logic       reset,
    input  logic [7:0] ps2_data,
    input  logic       ps2_ready,
    output logic       ps2_nextdata_n,
    input  logic       break_en,
    input  logic       repeat_filter,
    kbd_event_fifo_if.slave evq
);

    localparam int AW = $clog2(DEPTH);

    logic            ack_r;
    logic [7:0]      byte_r;
    dec_state_t      state;
    logic            held_v;
    logic [8:0]      held;
    logic            overflow_r;
    logic            cur_ext;
    logic            cur_brk;
    logic            is_code;
    logic            key_match;
    logic            push;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EV_W-1:0] event_w;
    logic [AW:0]     fifo_count;

    // ack_r doubles as "byte_r holds a fresh byte"; it is high for one cycle only.
    always_ff @(posedge CLK50) begin
        if (reset) begin
            ack_r  <= 1'b0;
            byte_r <= '0;
        end else begin
            ack_r <= ps2_ready && !ack_r;
            if (ps2_ready && !ack_r)
                byte_r <= ps2_data;
        end
    end

    assign ps2_nextdata_n = !ack_r;

    assign cur_ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign cur_brk   = (state == ST_BRK) || (state == ST_EXT_BRK);
    assign is_code   = ack_r && is_code_byte(byte_r);
    assign key_match = held_v && (held == {cur_ext, byte_r});
    assign push      = is_code && (cur_brk ? break_en : !(repeat_filter && key_match));

    // NOTE: assign a full default first so no path through always_comb infers a latch.
    always_comb begin
        event_w         = '0;
        event_w[EV_BRK] = cur_brk;
        event_w[EV_EXT] = cur_ext;
        event_w[7:0]    = byte_r;
    end

    always_ff @(posedge CLK50) begin
        if (reset) begin
            state  <= ST_IDLE;
            held_v <= 1'b0;
            held   <= '0;
        end else if (ack_r) begin
            if (byte_r == SC_EXT)
                state <= cur_brk ? ST_EXT_BRK : ST_EXT;
            else if (byte_r == SC_BRK)
                state <= cur_ext ? ST_EXT_BRK : ST_BRK;
            else
                state <= ST_IDLE;

            // Held-key tracking follows the keyboard, independent of what is queued.
            if (is_code) begin
                if (!cur_brk) begin
                    held   <= {cur_ext, byte_r};
                    held_v <= 1'b1;
                end else if (key_match) begin
                    held_v <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK50) begin
        if (reset || evq.clear)
            overflow_r <= 1'b0;
        else if (push && fifo_full && !evq.pop)
            overflow_r <= 1'b1;
    end

    kbd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .CLK50   (CLK50),
        .reset   (reset),
        .push    (push),
        .pop     (evq.pop),
        .clear   (evq.clear),
        .wr_data (event_w),
        .rd_data (evq.ev_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign evq.count    = fifo_count;
    assign evq.ev_valid = !fifo_empty;
    assign evq.overflow = overflow_r;

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Self-checking bench for kbd_event_fifo (DEPTH=4): vector table plus
// hand-written corner sequences, head events checked against a scoreboard.
module tb_kbd_event_fifo;

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] b;
        logic       brk_en;
        logic       rf;
        logic       exp_push;
        logic [9:0] exp_ev;
    } vec_t;

    logic       CLK50 = 1'b0;
    logic       reset;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_nextdata_n;
    logic       break_en;
    logic       repeat_filter;

    int         total = 0;
    int         bad   = 0;
    logic [9:0] sb[$];
    vec_t       vecs[$];
    int         model_cnt;
    logic [2:0] cnt_at_ack;

    kbd_event_fifo_if #(.DEPTH(DEPTH)) evq ();

    kbd_event_fifo #(.DEPTH(DEPTH)) dut (
        .CLK50          (CLK50),
        .reset          (reset),
        .ps2_data       (ps2_data),
        .ps2_ready      (ps2_ready),
        .ps2_nextdata_n (ps2_nextdata_n),
        .break_en       (break_en),
        .repeat_filter  (repeat_filter),
        .evq            (evq)
    );

    always #10 CLK50 = ~CLK50;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK50);
        reset = 1'b1;
        @(negedge CLK50);
        reset = 1'b0;
    endtask

    // Offer one byte; returns at the negedge two cycles after acceptance.
    task automatic send_byte(input logic [7:0] b, input logic with_pop);
        logic       seen;
        logic [9:0] exp;
        seen = 1'b0;
        @(negedge CLK50);
        ps2_data  = b;
        ps2_ready = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge CLK50);
            if (ps2_nextdata_n == 1'b0)
                seen = 1'b1;
        end
        check($sformatf("ack_seen_%02h", b), 32'(seen), 32'd1);
        cnt_at_ack = evq.count;
        ps2_ready  = 1'b0;
        if (with_pop) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL fullpop_head: scoreboard empty, got %03h", evq.ev_data);
            end else begin
                exp = sb.pop_front();
                check("fullpop_head", 32'(evq.ev_data), 32'(exp));
            end
            evq.pop = 1'b1;
        end
        @(negedge CLK50);
        evq.pop = 1'b0;
        check($sformatf("ack_release_%02h", b), 32'(ps2_nextdata_n), 32'd1);
    endtask

    task automatic pop_check(input string name);
        logic [9:0] exp;
        @(negedge CLK50);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %03h", name, evq.ev_data);
        end else begin
            exp = sb.pop_front();
            check({name, "_valid"}, 32'(evq.ev_valid), 32'd1);
            check(name, 32'(evq.ev_data), 32'(exp));
        end
        evq.pop = 1'b1;
        @(negedge CLK50);
        evq.pop = 1'b0;
    endtask

    task automatic drain(input string name);
        while (sb.size() > 0)
            pop_check(name);
        check({name, "_count0"}, 32'(evq.count), 32'd0);
        check({name, "_valid0"}, 32'(evq.ev_valid), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        ps2_data      = '0;
        ps2_ready     = 1'b0;
        break_en      = 1'b0;
        repeat_filter = 1'b0;
        evq.pop       = 1'b0;
        evq.clear     = 1'b0;

        vecs.push_back(vec_t'{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h1C, 1'b0, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hE0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hF0, 1'b1, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h75, 1'b1, 1'b0, 1'b1, 10'h375});
        vecs.push_back(vec_t'{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h75, 1'b0, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h1C, 1'b0, 1'b1, 1'b1, 10'h01C});
        vecs.push_back(vec_t'{8'h1C, 1'b0, 1'b1, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h1C, 1'b0, 1'b1, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hF0, 1'b0, 1'b1, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h1C, 1'b0, 1'b1, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h1C, 1'b0, 1'b1, 1'b1, 10'h01C});
        vecs.push_back(vec_t'{8'h1C, 1'b0, 1'b1, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b0, 10'h000});
        vecs.push_back(vec_t'{8'h75, 1'b0, 1'b0, 1'b1, 10'h075});
        vecs.push_back(vec_t'{8'hFF, 1'b0, 1'b0, 1'b0, 10'h000});

        repeat (3) @(negedge CLK50);
        reset = 1'b0;
        @(negedge CLK50);
        check("rst_nextdata_n", 32'(ps2_nextdata_n), 32'd1);
        check("rst_ev_valid", 32'(evq.ev_valid), 32'd0);
        check("rst_ev_data", 32'(evq.ev_data), 32'd0);
        check("rst_count", 32'(evq.count), 32'd0);
        check("rst_overflow", 32'(evq.overflow), 32'd0);

        // Single make: visible two cycles after accept, not one.
        send_byte(8'h1C, 1'b0);
        sb.push_back(10'h01C);
        check("first_count_at_ack", 32'(cnt_at_ack), 32'd0);
        check("first_count", 32'(evq.count), 32'd1);
        check("first_valid", 32'(evq.ev_valid), 32'd1);
        check("first_data", 32'(evq.ev_data), 32'h01C);
        drain("first_pop");

        // Table: prefixes, break_en, repeat filter, receiver error codes.
        model_cnt = 0;
        foreach (vecs[i]) begin
            break_en      = vecs[i].brk_en;
            repeat_filter = vecs[i].rf;
            send_byte(vecs[i].b, 1'b0);
            if (vecs[i].exp_push) begin
                sb.push_back(vecs[i].exp_ev);
                model_cnt++;
            end
            check($sformatf("vec%0d_count", i), 32'(evq.count), 32'(model_cnt));
        end
        check("vec_overflow", 32'(evq.overflow), 32'd0);
        drain("vec_pop");

        // Overflow: fifth make dropped, the oldest four survive in order.
        break_en      = 1'b0;
        repeat_filter = 1'b0;
        send_byte(8'h15, 1'b0);
        send_byte(8'h1D, 1'b0);
        send_byte(8'h24, 1'b0);
        send_byte(8'h2D, 1'b0);
        check("ovf_before", 32'(evq.overflow), 32'd0);
        send_byte(8'h2C, 1'b0);
        sb.push_back(10'h015);
        sb.push_back(10'h01D);
        sb.push_back(10'h024);
        sb.push_back(10'h02D);
        check("ovf_count", 32'(evq.count), 32'd4);
        check("ovf_flag", 32'(evq.overflow), 32'd1);
        drain("ovf_pop");
        check("empty_data", 32'(evq.ev_data), 32'd0);

        // Pop on empty is ignored.
        @(negedge CLK50);
        evq.pop = 1'b1;
        @(negedge CLK50);
        evq.pop = 1'b0;
        check("empty_pop_count", 32'(evq.count), 32'd0);
        check("ovf_sticky", 32'(evq.overflow), 32'd1);

        // Clear flushes entries and overflow.
        send_byte(8'h15, 1'b0);
        send_byte(8'h1D, 1'b0);
        check("pre_clear_count", 32'(evq.count), 32'd2);
        @(negedge CLK50);
        evq.clear = 1'b1;
        @(negedge CLK50);
        evq.clear = 1'b0;
        check("clear_count", 32'(evq.count), 32'd0);
        check("clear_valid", 32'(evq.ev_valid), 32'd0);
        check("clear_overflow", 32'(evq.overflow), 32'd0);

        // Full FIFO: push and pop in the same cycle.
        send_byte(8'h15, 1'b0);
        send_byte(8'h1D, 1'b0);
        send_byte(8'h24, 1'b0);
        send_byte(8'h2D, 1'b0);
        sb.push_back(10'h015);
        sb.push_back(10'h01D);
        sb.push_back(10'h024);
        sb.push_back(10'h02D);
        check("full_count", 32'(evq.count), 32'd4);
        send_byte(8'h35, 1'b1);
        sb.push_back(10'h035);
        check("pushpop_count", 32'(evq.count), 32'd4);
        check("pushpop_head", 32'(evq.ev_data), 32'h01D);
        check("pushpop_overflow", 32'(evq.overflow), 32'd0);
        drain("pushpop_pop");

        // Reset between E0 and 75 discards the prefix and the queue.
        send_byte(8'h1C, 1'b0);
        send_byte(8'hE0, 1'b0);
        check("prerst_count", 32'(evq.count), 32'd1);
        do_reset();
        sb.delete();
        check("midrst_count", 32'(evq.count), 32'd0);
        check("midrst_valid", 32'(evq.ev_valid), 32'd0);
        check("midrst_nextdata_n", 32'(ps2_nextdata_n), 32'd1);
        break_en = 1'b1;
        send_byte(8'h75, 1'b0);
        sb.push_back(10'h075);
        check("midrst_ev_count", 32'(evq.count), 32'd1);
        check("midrst_ev_data", 32'(evq.ev_data), 32'h075);
        drain("midrst_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
